// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: standard raster geometries and sizing helpers for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int display;
        int front;
        int sync;
        int back;
    } axis_t;

    localparam axis_t VGA_640X480_H  = '{640, 16, 96, 48};
    localparam axis_t VGA_640X480_V  = '{480, 10, 2, 33};
    localparam axis_t SVGA_800X600_H = '{800, 40, 128, 88};
    localparam axis_t SVGA_800X600_V = '{600, 1, 4, 23};

    function automatic int axis_total(input int display, input int front, input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int h_total(input axis_t a);
        return axis_total(a.display, a.front, a.sync, a.back);
    endfunction

    function automatic int v_total(input axis_t a);
        return axis_total(a.display, a.front, a.sync, a.back);
    endfunction

    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen_param_pixel_tick_div.sv
// pixel_tick_div: divides clk by CLK_DIV into a registered one-clk pixel strobe.
module pixel_tick_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic tick_next
);

    localparam int CW = ctr_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // tick_next is the value tick takes on the coming edge, so the counters can move in step with it
    assign tick_next = cnt == LAST;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= tick_next ? '0 : cnt + 1'b1;
            tick <= tick_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param: parametrised raster timing with sync polarity, pixel divider and line/frame strobes.
module vga_timing_gen_param
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_640X480_H.display,
    parameter int H_FRONT   = VGA_640X480_H.front,
    parameter int H_SYNC    = VGA_640X480_H.sync,
    parameter int H_BACK    = VGA_640X480_H.back,
    parameter int V_DISPLAY = VGA_640X480_V.display,
    parameter int V_FRONT   = VGA_640X480_V.front,
    parameter int V_SYNC    = VGA_640X480_V.sync,
    parameter int V_BACK    = VGA_640X480_V.back,
    parameter int CLK_DIV   = 4,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int XW        = 10,
    parameter int YW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          p_tick,
    output logic          line_start,
    output logic          frame_start,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y
);

    localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_DISPLAY);
    localparam logic [XW-1:0] HS_BEG = XW'(H_DISPLAY + H_FRONT);
    localparam logic [XW-1:0] HS_END = XW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_DISPLAY);
    localparam logic [YW-1:0] VS_BEG = YW'(V_DISPLAY + V_FRONT);
    localparam logic [YW-1:0] VS_END = YW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > 2**XW || V_TOTAL > 2**YW || CLK_DIV < 1 || H_BACK < 1 || V_BACK < 1) begin : g_bad_geometry
        $error("vga_timing_gen_param: illegal geometry or counter width");
    end

    logic adv;
    logic x_wrap;
    logic y_wrap;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .reset     (reset),
        .tick      (p_tick),
        .tick_next (adv)
    );

    always_comb begin
        x_wrap = adv && pixel_x == X_LAST;
        y_wrap = x_wrap && pixel_y == Y_LAST;
        x_nxt  = !adv ? pixel_x : x_wrap ? '0 : pixel_x + 1'b1;
        y_nxt  = !x_wrap ? pixel_y : y_wrap ? '0 : pixel_y + 1'b1;
    end

    // derived outputs come from the next-state counters so they never skew against pixel_x/pixel_y
    always_ff @(posedge clk) begin
        if (!reset) begin
            pixel_x     <= X_LAST;
            pixel_y     <= Y_LAST;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            hsync       <= (x_nxt >= HS_BEG && x_nxt <= HS_END) ? H_POL : ~H_POL;
            vsync       <= (y_nxt >= VS_BEG && y_nxt <= VS_END) ? V_POL : ~V_POL;
            video_on    <= x_nxt < X_ACT && y_nxt < Y_ACT;
            line_start  <= x_wrap;
            frame_start <= y_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// tb_vga_timing_gen_param: directed checks on a default 640x480 instance and a tiny CLK_DIV=1 raster.
module tb_vga_timing_gen_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_d = 1'b0;
    logic reset_s = 1'b0;

    logic d_hs, d_vs, d_von, d_pt, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic s_hs, s_vs, s_von, s_pt, s_ls, s_fs;
    logic [3:0] s_x;
    logic [2:0] s_y;

    int checks = 0;
    int failures = 0;

    vga_timing_gen_param dut_d (
        .clk (clk), .reset (reset_d), .hsync (d_hs), .vsync (d_vs), .video_on (d_von),
        .p_tick (d_pt), .line_start (d_ls), .frame_start (d_fs), .pixel_x (d_x), .pixel_y (d_y)
    );

    vga_timing_gen_param #(
        .H_DISPLAY (8), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .CLK_DIV (1), .H_POL (1'b1), .V_POL (1'b1), .XW (4), .YW (3)
    ) dut_s (
        .clk (clk), .reset (reset_s), .hsync (s_hs), .vsync (s_vs), .video_on (s_von),
        .p_tick (s_pt), .line_start (s_ls), .frame_start (s_fs), .pixel_x (s_x), .pixel_y (s_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_cnt, hs_first, von_first, ls_cyc, ex, ey;
        hs_cnt = 0; hs_first = -1; von_first = -1; ls_cyc = -1;
        repeat (3) @(negedge clk);
        chk("d_rst_x", d_x, 799);
        chk("d_rst_y", d_y, 524);
        chk("d_rst_hs", d_hs, 1);
        chk("d_rst_vs", d_vs, 1);
        chk("d_rst_von", d_von, 0);
        chk("d_rst_pt", d_pt, 0);
        chk("d_rst_ls", d_ls, 0);
        chk("d_rst_fs", d_fs, 0);
        chk("s_rst_x", s_x, 11);
        chk("s_rst_y", s_y, 6);
        chk("s_rst_hs", s_hs, 0);
        chk("s_rst_vs", s_vs, 0);
        chk("s_rst_von", s_von, 0);
        reset_d = 1'b1;
        repeat (3) @(negedge clk);
        chk("d_pre_pt", d_pt, 0);
        chk("d_pre_x", d_x, 799);
        chk("d_pre_fs", d_fs, 0);
        @(negedge clk);
        chk("d_first_pt", d_pt, 1);
        chk("d_first_x", d_x, 0);
        chk("d_first_y", d_y, 0);
        chk("d_first_fs", d_fs, 1);
        chk("d_first_ls", d_ls, 1);
        chk("d_first_von", d_von, 1);
        chk("d_first_hs", d_hs, 1);
        chk("d_first_vs", d_vs, 1);
        @(negedge clk);
        chk("d_hold_pt", d_pt, 0);
        chk("d_hold_ls", d_ls, 0);
        chk("d_hold_fs", d_fs, 0);
        chk("d_hold_x", d_x, 0);
        for (int c = 2; c <= 3200; c++) begin
            @(negedge clk);
            if (d_pt && !d_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_x);
            end
            if (d_pt && !d_von && von_first < 0) von_first = int'(d_x);
            if (d_ls && ls_cyc < 0) ls_cyc = c;
        end
        chk("d_hs_width", hs_cnt, 96);
        chk("d_hs_first_x", hs_first, 656);
        chk("d_von_fall_x", von_first, 640);
        chk("d_line_period", ls_cyc, 3200);
        chk("d_line1_x", d_x, 0);
        chk("d_line1_y", d_y, 1);
        repeat (3199) @(negedge clk);
        chk("d_prewrap_x", d_x, 799);
        chk("d_prewrap_y", d_y, 1);
        reset_d = 1'b0;
        @(negedge clk);
        chk("d_rstwrap_pt", d_pt, 0);
        chk("d_rstwrap_ls", d_ls, 0);
        chk("d_rstwrap_fs", d_fs, 0);
        chk("d_rstwrap_x", d_x, 799);
        chk("d_rstwrap_y", d_y, 524);
        chk("d_rstwrap_hs", d_hs, 1);
        reset_d = 1'b1;
        repeat (3) @(negedge clk);
        chk("d_rel2_fs_early", d_fs, 0);
        @(negedge clk);
        chk("d_rel2_fs", d_fs, 1);
        chk("d_rel2_x", d_x, 0);
        chk("d_rel2_y", d_y, 0);
        reset_s = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 100; c++) begin
            ex = c % 12;
            ey = (c / 12) % 7;
            chk("s_pt", s_pt, 1);
            chk("s_x", s_x, ex);
            chk("s_y", s_y, ey);
            chk("s_hs", s_hs, ex >= 9 && ex <= 10);
            chk("s_vs", s_vs, ey == 5);
            chk("s_von", s_von, ex < 8 && ey < 4);
            chk("s_ls", s_ls, ex == 0);
            chk("s_fs", s_fs, ex == 0 && ey == 0);
            @(negedge clk);
        end
        reset_s = 1'b0;
        @(negedge clk);
        chk("s_mid_rst_x", s_x, 11);
        chk("s_mid_rst_y", s_y, 6);
        chk("s_mid_rst_pt", s_pt, 0);
        chk("s_mid_rst_ls", s_ls, 0);
        chk("s_mid_rst_fs", s_fs, 0);
        chk("s_mid_rst_hs", s_hs, 0);
        chk("s_mid_rst_vs", s_vs, 0);
        chk("s_mid_rst_von", s_von, 0);
        reset_s = 1'b1;
        @(negedge clk);
        chk("s_rel_fs", s_fs, 1);
        chk("s_rel_pt", s_pt, 1);
        chk("s_rel_x", s_x, 0);
        chk("s_rel_y", s_y, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
